// File: rtl/fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller for a single-clock FIFO. It waits until a full burst
// of BURST_LEN words is stored, then pops exactly BURST_LEN words with rdreq,
// absorbs the FIFO's one-cycle q latency in a 2-entry output buffer, and hands
// the words downstream over a valid/ready handshake (po_flag / po_ready).
//
// Optional feature (compile-time macro FIFO_RD_TIMEOUT_EN):
//   when defined, a partial burst (0 < usedw < BURST_LEN) that has sat in the
//   FIFO for TIMEOUT_CYC idle cycles is flushed as a shorter burst.
//   When undefined, partial data waits until the threshold is reached.
//
// Ports:
//   sys_clk     in   system clock
//   sys_rst_n   in   asynchronous active-low reset
//   fifo_q      in   FIFO read data, valid the cycle after rdreq
//   fifo_empty  in   FIFO empty flag
//   fifo_full   in   FIFO full flag (usedw wraps to 0 when full)
//   fifo_usedw  in   FIFO occupancy
//   rdreq       out  FIFO read request
//   po_data     out  output word (head of the output buffer)
//   po_flag     out  output valid
//   po_ready    in   downstream accept
//   burst_busy  out  high while a burst is being read
//   burst_done  out  one-cycle pulse at the end of each burst
// ---------------------------------------------------------------------------
module fifo_rd_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int BURST_LEN   = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  input  logic              fifo_full,
  input  logic [ADDR_W-1:0] fifo_usedw,
  output logic              rdreq,
  output logic [DATA_W-1:0] po_data,
  output logic              po_flag,
  input  logic              po_ready,
  output logic              burst_busy,
  output logic              burst_done
);

  // rd_cnt needs one extra bit so BURST_LEN == 2^ADDR_W is representable.
  localparam int              CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               inflight_q;       // rdreq was issued last cycle
  logic [DATA_W-1:0]  buf_q [2];
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         occ_q;

  logic               avail;
  logic               pop;
  logic [2:0]         credit_sum;
  logic               credit;
  logic               timeout_hit;

  // usedw wraps to 0 when all 2^ADDR_W words are stored, so full counts too.
  assign avail = fifo_full | ({1'b0, fifo_usedw} >= BURST_CNT);

  assign po_flag = (occ_q != 2'd0);
  assign po_data = buf_q[rd_ptr_q];
  assign pop     = po_flag & po_ready;

  // Entries the buffer will hold once the in-flight word lands and this
  // cycle's pop leaves; one more request is safe only if that is <= 1.
  assign credit_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit     = (credit_sum <= 3'd1);

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] idle_cnt_q;
  logic            partial;

  assign partial     = (fifo_usedw != '0) & ({1'b0, fifo_usedw} < BURST_CNT) & ~fifo_full;
  assign timeout_hit = (state_q == IDLE) & partial & (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt_q <= '0;
    end else if ((state_q != IDLE) || (state_d != IDLE) || (fifo_usedw == '0)) begin
      idle_cnt_q <= '0;
    end else if (partial) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Burst FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    rdreq      = 1'b0;
    burst_busy = 1'b0;
    burst_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (avail) begin
          state_d  = READ;
          rd_cnt_d = BURST_CNT;
        end else if (timeout_hit) begin
          state_d  = READ;
          rd_cnt_d = {1'b0, fifo_usedw};
        end
      end

      READ: begin
        burst_busy = 1'b1;
        rdreq      = (rd_cnt_q != '0) & ~fifo_empty & credit;
        if (rdreq) begin
          rd_cnt_d = rd_cnt_q - 1'b1;
        end
        // Leave only once every requested word has been handed downstream.
        if ((rd_cnt_q == '0) && !inflight_q && (occ_q == 2'd0)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        burst_done = 1'b1;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output buffer: the word requested last cycle is on fifo_q now and is
  // written into the tail entry at the end of this cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      inflight_q <= rdreq;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= fifo_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_rd_ctrl
//
// Drives fifo_rd_ctrl from a behavioural 256x8 FIFO (queue with registered
// q). Every word written is pushed onto an expected queue; a monitor pops it
// whenever the DUT hands a word downstream and compares. Reset discards
// whatever already left the FIFO, so while reset is held the expected queue
// is resynchronised to the words still stored in the FIFO.
// ---------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int BURST_LEN   = 16;
  localparam int TIMEOUT_CYC = 1000;
  localparam int DEPTH       = 256;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [DATA_W-1:0] fifo_q = '0;
  logic              fifo_empty = 1'b1;
  logic              fifo_full = 1'b0;
  logic [ADDR_W-1:0] fifo_usedw = '0;
  logic              rdreq;
  logic [DATA_W-1:0] po_data;
  logic              po_flag;
  logic              po_ready;
  logic              burst_busy;
  logic              burst_done;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] exp_q[$];

  int cyc = 0;
  int rd_issued = 0;
  int delivered = 0;
  int burst_rd = 0;
  int done_cnt = 0;
  int rd_run = 0;
  int last_rd_run = 0;
  int flag_run = 0;
  int last_flag_run = 0;
  int exp_burst_len = BURST_LEN;
  int ready_mode = 0;

  fifo_rd_ctrl #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .BURST_LEN  (BURST_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .fifo_q    (fifo_q),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_usedw(fifo_usedw),
    .rdreq     (rdreq),
    .po_data   (po_data),
    .po_flag   (po_flag),
    .po_ready  (po_ready),
    .burst_busy(burst_busy),
    .burst_done(burst_done)
  );

  always #10 sys_clk = ~sys_clk;

  function automatic void check_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void check_le(input string name, input int act, input int bound);
    n_checks++;
    if (act > bound) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected <= %0d (t=%0t)", name, act, bound, $time);
    end
  endfunction

  // Behavioural FIFO plus event counters, all sampled at the active edge.
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (rdreq) begin
      check_le("rdreq_nonempty", 1, fq.size());
      if (fq.size() != 0) fifo_q <= fq.pop_front();
    end
    if (wr_en && fq.size() < DEPTH) fq.push_back(wr_data);
    fifo_usedw <= ADDR_W'(fq.size());
    fifo_full  <= (fq.size() == DEPTH);
    fifo_empty <= (fq.size() == 0);

    if (!sys_rst_n) begin
      rd_issued <= 0;
      delivered <= 0;
      burst_rd  <= 0;
      rd_run    <= 0;
      flag_run  <= 0;
    end else begin
      if (rdreq) begin
        rd_issued <= rd_issued + 1;
        rd_run    <= rd_run + 1;
      end else if (rd_run != 0) begin
        last_rd_run <= rd_run;
        rd_run      <= 0;
      end
      if (po_flag) flag_run <= flag_run + 1;
      else if (flag_run != 0) begin
        last_flag_run <= flag_run;
        flag_run      <= 0;
      end
      if (po_flag && po_ready) delivered <= delivered + 1;
      if (burst_done) begin
        done_cnt <= done_cnt + 1;
        burst_rd <= 0;
      end else if (rdreq) begin
        burst_rd <= burst_rd + 1;
      end
    end
  end

  // Monitor / scoreboard, sampled on the inactive edge.
  initial begin : monitor
    logic              prev_stall;
    logic              prev_done;
    logic [DATA_W-1:0] prev_data;
    logic [DATA_W-1:0] exp_word;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        exp_q      = fq;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        check_eq("rst_rdreq", int'(rdreq), 0);
        check_eq("rst_po_flag", int'(po_flag), 0);
        check_eq("rst_burst_busy", int'(burst_busy), 0);
        check_eq("rst_burst_done", int'(burst_done), 0);
      end else begin
        check_le("outstanding", rd_issued - delivered, 2);
        if (prev_stall) begin
          check_eq("stall_po_flag", int'(po_flag), 1);
          check_eq("stall_po_data", int'(po_data), int'(prev_data));
        end
        if (po_flag && po_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_word", int'(po_data), -1);
          end else begin
            exp_word = exp_q.pop_front();
            check_eq("po_data", int'(po_data), int'(exp_word));
            $display("xfer data=%0d", po_data);
          end
        end
        prev_stall = po_flag && !po_ready;
        prev_data  = po_data;
        if (burst_done) begin
          check_eq("burst_done_width", int'(prev_done), 0);
          check_eq("burst_len", burst_rd, exp_burst_len);
        end
        prev_done = burst_done;
      end
    end
  end

  // Downstream ready pattern.
  initial begin : ready_drv
    int k;
    k = 0;
    po_ready = 1'b1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (ready_mode)
        0:       po_ready = 1'b1;
        1:       po_ready = ((k % 3) == 0);
        default: po_ready = 1'($urandom_range(0, 1));
      endcase
      k++;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(name, done_cnt, target);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    int d0;
    int n;
    sys_rst_n = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;

    // 1: reset held with 20 words preloaded, then one burst after release
    repeat (3) tick();
    for (int i = 0; i < 20; i++) write_word(DATA_W'(100 + i));
    repeat (5) tick();
    check_eq("t1_no_rdreq_in_reset", rd_issued, 0);
    d0 = done_cnt;
    sys_rst_n = 1'b1;
    wait_done(d0 + 1, 200, "t1_burst_done");
    repeat (30) tick();
    check_eq("t1_reads", rd_issued, 16);
    check_eq("t1_left_in_fifo", fq.size(), 4);
    for (int i = 0; i < 12; i++) write_word(DATA_W'(120 + i));
    wait_done(d0 + 2, 200, "t1_second_burst");
    repeat (5) tick();
    check_eq("t1_fifo_empty", fq.size(), 0);
    check_eq("t1_all_delivered", exp_q.size(), 0);

    // 2: threshold, 15 words never start a burst, the 16th does
    for (int i = 0; i < 15; i++) write_word(DATA_W'(i));
    base = rd_issued;
    repeat (100) tick();
    check_eq("t2_no_rdreq_below_threshold", rd_issued, base);
    d0 = done_cnt;
    write_word(DATA_W'(15));
    wait_done(d0 + 1, 200, "t2_burst_done");
    repeat (5) tick();
    check_eq("t2_reads", rd_issued - base, 16);
    check_eq("t2_rdreq_run", last_rd_run, 16);
    check_eq("t2_po_flag_run", last_flag_run, 16);
    check_eq("t2_fifo_empty", fq.size(), 0);
    check_eq("t2_all_delivered", exp_q.size(), 0);

    // 3: backpressure 1,0,0 repeating
    ready_mode = 1;
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) write_word(DATA_W'($urandom_range(0, 255)));
    wait_done(d0 + 1, 400, "t3_burst_done");
    repeat (5) tick();
    check_eq("t3_fifo_empty", fq.size(), 0);
    check_eq("t3_all_delivered", exp_q.size(), 0);

    // 4: full FIFO (usedw wraps to 0), 16 bursts with random ready
    ready_mode = 2;
    sys_rst_n  = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) write_word(DATA_W'($urandom_range(0, 255)));
    repeat (3) tick();
    d0 = done_cnt;
    sys_rst_n = 1'b1;
    repeat (3) tick();
    check_le("t4_burst_started_when_full", 1, rd_issued);
    wait_done(d0 + 16, 5000, "t4_sixteen_bursts");
    repeat (10) tick();
    check_eq("t4_reads", rd_issued, DEPTH);
    check_eq("t4_fifo_empty", fq.size(), 0);
    check_eq("t4_all_delivered", exp_q.size(), 0);

    // 5: reset after 5 accepted words
    ready_mode = 0;
    repeat (3) tick();
    base = delivered;
    for (int i = 0; i < 16; i++) write_word(DATA_W'(50 + i));
    n = 0;
    while (delivered - base < 5 && n < 200) begin
      tick();
      n++;
    end
    check_eq("t5_five_accepted", delivered - base, 5);
    sys_rst_n = 1'b0;
    #1;
    check_eq("t5_async_rdreq", int'(rdreq), 0);
    check_eq("t5_async_po_flag", int'(po_flag), 0);
    check_eq("t5_async_po_data", int'(po_data), 0);
    check_eq("t5_async_busy", int'(burst_busy), 0);
    check_eq("t5_async_done", int'(burst_done), 0);
    tick();
    tick();
    sys_rst_n = 1'b1;
    repeat (200) tick();
    check_eq("t5_no_rdreq_after_reset", rd_issued, 0);
    check_le("t5_words_left", fq.size(), 11);
    d0 = done_cnt;
    n  = BURST_LEN - fq.size();
    for (int i = 0; i < n; i++) write_word(DATA_W'(80 + i));
    wait_done(d0 + 1, 200, "t5_cleanup_burst");
    repeat (5) tick();
    check_eq("t5_fifo_empty", fq.size(), 0);
    check_eq("t5_all_delivered", exp_q.size(), 0);

    // 6: five-word partial burst
    base = rd_issued;
    d0   = done_cnt;
`ifdef FIFO_RD_TIMEOUT_EN
    begin
      int c0;
      exp_burst_len = 5;
      write_word(DATA_W'(200));
      c0 = cyc;
      for (int i = 1; i < 5; i++) write_word(DATA_W'(200 + i));
      n = 0;
      while (rd_issued == base && n < TIMEOUT_CYC + 50) begin
        tick();
        n++;
      end
      check_le("t6_timeout_not_early", TIMEOUT_CYC, cyc - c0);
      check_le("t6_timeout_not_late", cyc - c0, TIMEOUT_CYC + 2);
      wait_done(d0 + 1, 100, "t6_partial_burst_done");
      repeat (5) tick();
      check_eq("t6_reads", rd_issued - base, 5);
      check_eq("t6_fifo_empty", fq.size(), 0);
      exp_burst_len = BURST_LEN;
    end
`else
    for (int i = 0; i < 5; i++) write_word(DATA_W'(200 + i));
    repeat (2 * TIMEOUT_CYC) tick();
    check_eq("t6_no_rdreq_partial", rd_issued, base);
    check_eq("t6_no_burst_done", done_cnt, d0);
    check_eq("t6_words_kept", fq.size(), 5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
